// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

  localparam int unsigned DEFAULT_WIDTH = 16;

  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
interface serial_subtractor_if
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff_out;
  logic             borrow_out;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, diff_out, borrow_out
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, diff_out, borrow_out
  );

endinterface

// File: rtl/serial_subtractor_half_subtractor.sv
// One-bit half subtractor; two of these plus an OR make a full-subtract cell.
module half_subtractor (
  input  logic A_in,
  input  logic B_in,
  output logic D_out,
  output logic Bo_out
);

  assign D_out  = A_in ^ B_in;
  assign Bo_out = ~A_in & B_in;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b, LSB first, WIDTH cycles per operation.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int unsigned     CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             d1, bo1, d_bit, bo2, cell_bout;
  logic             in_ready;
  logic [WIDTH-1:0] res_shift;

  half_subtractor u_hs_ab (
    .A_in   (a_sr_q[0]),
    .B_in   (b_sr_q[0]),
    .D_out  (d1),
    .Bo_out (bo1)
  );

  half_subtractor u_hs_bin (
    .A_in   (d1),
    .B_in   (borrow_q),
    .D_out  (d_bit),
    .Bo_out (bo2)
  );

  assign cell_bout = bo1 | bo2;
  // New difference bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  assign res_shift = WIDTH'({d_bit, res_q} >> 1);
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE && bus.out_ready) state_d = IDLE;
        if (bus.in_valid && in_ready) begin
          a_sr_d   = bus.a_in;
          b_sr_d   = bus.b_in;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_d    = res_shift;
        borrow_d = cell_bout;
        if (cnt_q == LAST) begin
          // Results are latched separately so outputs stay put during the next RUN.
          diff_d  = res_shift;
          bout_d  = cell_bout;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = (state_q == DONE);
  assign bus.diff_out   = diff_q;
  assign bus.borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH 8, 16 and 2.
module tb_serial_subtractor;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  serial_subtractor_if #(.WIDTH(8))  if8  ();
  serial_subtractor_if #(.WIDTH(16)) if16 ();
  serial_subtractor_if #(.WIDTH(2))  if2  ();

  serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  serial_subtractor #(.WIDTH(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(if2));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  vec_t tbl [7];
  vec_t b2b [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic txn8(input string name, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ed, input logic eb);
    int cyc;
    @(negedge clk);
    cyc = 0;
    while (!if8.in_ready && cyc < 50) begin @(negedge clk); cyc++; end
    if8.a_in = a; if8.b_in = b; if8.in_valid = 1'b1; if8.out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    if8.in_valid = 1'b0;
    cyc = 0;
    while (!if8.out_valid && cyc < 50) begin @(negedge clk); cyc++; end
    check({name, " latency"}, 64'(cyc), 64'd8);
    check({name, " diff"}, 64'(if8.diff_out), 64'(ed));
    check({name, " borrow"}, 64'(if8.borrow_out), 64'(eb));
    if8.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    if8.out_ready = 1'b0;
    check({name, " drained"}, {62'd0, if8.out_valid, if8.in_ready}, 64'b01);
  endtask

  task automatic rnd16(input int n);
    logic [15:0] a, b;
    logic [16:0] exp;
    int cyc;
    for (int i = 0; i < n; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      exp = {1'b0, a} - {1'b0, b};
      @(negedge clk);
      if16.a_in = a; if16.b_in = b; if16.in_valid = 1'b1; if16.out_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      if16.in_valid = 1'b0;
      cyc = 0;
      while (!if16.out_valid && cyc < 100) begin @(negedge clk); cyc++; end
      check("rand16", {46'd0, if16.out_valid, if16.borrow_out, if16.diff_out}, {46'd0, 1'b1, exp});
      if16.out_ready = 1'b1;
      @(posedge clk);
      #1 if16.out_ready = 1'b0;
    end
  endtask

  task automatic rnd2(input int n);
    logic [1:0] a, b;
    logic [2:0] exp;
    int cyc;
    for (int i = 0; i < n; i++) begin
      a = 2'($urandom_range(0, 3)); b = 2'($urandom_range(0, 3));
      exp = {1'b0, a} - {1'b0, b};
      @(negedge clk);
      if2.a_in = a; if2.b_in = b; if2.in_valid = 1'b1; if2.out_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      if2.in_valid = 1'b0;
      cyc = 0;
      while (!if2.out_valid && cyc < 20) begin @(negedge clk); cyc++; end
      check("rand2", {60'd0, if2.out_valid, if2.borrow_out, if2.diff_out}, {60'd0, 1'b1, exp});
      if2.out_ready = 1'b1;
      @(posedge clk);
      #1 if2.out_ready = 1'b0;
    end
  endtask

  initial begin
    int cyc;
    n_cmp = 0;
    n_err = 0;
    tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
    tbl[2] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    tbl[3] = '{8'hA5, 8'hA5, 8'h00, 1'b0};
    tbl[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
    tbl[5] = '{8'h80, 8'h01, 8'h7F, 1'b0};
    tbl[6] = '{8'h01, 8'h80, 8'h81, 1'b1};
    b2b[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
    b2b[1] = '{8'h20, 8'h30, 8'hF0, 1'b1};
    b2b[2] = '{8'hC8, 8'h64, 8'h64, 1'b0};

    rst_n = 1'b0;
    if8.in_valid = 1'b0;  if8.out_ready = 1'b0;  if8.a_in = '0;  if8.b_in = '0;
    if16.in_valid = 1'b0; if16.out_ready = 1'b0; if16.a_in = '0; if16.b_in = '0;
    if2.in_valid = 1'b0;  if2.out_ready = 1'b0;  if2.a_in = '0;  if2.b_in = '0;
    repeat (3) @(negedge clk);
    check("reset in_ready", 64'(if8.in_ready), 64'd1);
    check("reset out_valid", 64'(if8.out_valid), 64'd0);
    check("reset outputs", {55'd0, if8.borrow_out, if8.diff_out}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      txn8($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].bo);

    // Back-pressure: result held in DONE for five cycles.
    @(negedge clk);
    if8.a_in = 8'h40; if8.b_in = 8'h0F; if8.in_valid = 1'b1; if8.out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    if8.in_valid = 1'b0;
    cyc = 0;
    while (!if8.out_valid && cyc < 50) begin @(negedge clk); cyc++; end
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp hold%0d", k),
            {53'd0, if8.out_valid, if8.in_ready, if8.borrow_out, if8.diff_out},
            {53'd0, 1'b1, 1'b0, 1'b0, 8'h31});
      @(negedge clk);
    end
    if8.out_ready = 1'b1;
    #1 check("bp in_ready comb", 64'(if8.in_ready), 64'd1);
    @(posedge clk); @(negedge clk);
    if8.out_ready = 1'b0;
    check("bp consumed", {62'd0, if8.out_valid, if8.in_ready}, 64'b01);

    // Back-to-back: three pairs, no idle gap between results.
    @(negedge clk);
    if8.a_in = b2b[0].a; if8.b_in = b2b[0].b; if8.in_valid = 1'b1; if8.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      if (k < 2) begin
        if8.a_in = b2b[k+1].a; if8.b_in = b2b[k+1].b;
      end else begin
        if8.in_valid = 1'b0;
      end
      cyc = 0;
      while (!if8.out_valid && cyc < 50) begin @(negedge clk); cyc++; end
      check($sformatf("b2b%0d latency", k), 64'(cyc), 64'd8);
      check($sformatf("b2b%0d result", k), {55'd0, if8.borrow_out, if8.diff_out},
            {55'd0, b2b[k].bo, b2b[k].d});
      check($sformatf("b2b%0d in_ready", k), 64'(if8.in_ready), 64'd1);
    end
    @(posedge clk); @(negedge clk);
    if8.out_ready = 1'b0;
    check("b2b idle", {62'd0, if8.out_valid, if8.in_ready}, 64'b01);

    // Reset in the middle of RUN.
    @(negedge clk);
    if8.a_in = 8'h33; if8.b_in = 8'h11; if8.in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    if8.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("run in_ready low", 64'(if8.in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("mid-run reset", {53'd0, if8.out_valid, if8.in_ready, if8.borrow_out, if8.diff_out},
          {53'd0, 1'b0, 1'b1, 1'b0, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    txn8("post-reset", 8'h10, 8'h01, 8'h0F, 1'b0);

    rnd16(1000);
    rnd2(1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
